// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding CPU load/store engine with size checks, load extension and fixed read latency.
module load_store_unit #(
    parameter int unsigned pReadWaitCycles = 32'd1
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwReqValid,
    output logic        owReqReady,
    input  logic        iwReqWrite,
    input  logic [1:0]  iwReqSize,
    input  logic        iwReqSigned,
    input  logic [31:0] iwReqAddr,
    input  logic [31:0] iwReqWData,
    output logic        orRespValid,
    output logic [31:0] orRespData,
    output logic        orRespError,
    output logic [31:0] orMemReadAddr,
    output logic [31:0] orMemWriteAddr,
    output logic [31:0] orMemWriteData,
    output logic [3:0]  orMemWstrb,
    input  logic [31:0] iwMemReadData
);
    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, ERROR} state_t;
    state_t      rState, wNext;
    logic [3:0]  rCnt;
    logic [1:0]  rSize;
    logic        rSigned;
    logic        wAccept, wBad, wLoadDone;
    logic [31:0] wLoadData;
    assign owReqReady = rState == IDLE;
    assign wAccept    = iwReqValid & owReqReady;
    assign wBad       = iwReqSize == 2'b11 || (iwReqSize == 2'b01 && iwReqAddr[0]) ||
                        (iwReqSize == 2'b10 && iwReqAddr[1:0] != 2'b00);
    assign wLoadDone  = rState == READ_WAIT && rCnt <= 4'd1;
    assign wLoadData  = rSize == 2'b00 ? {{24{rSigned & iwMemReadData[7]}}, iwMemReadData[7:0]} :
                        rSize == 2'b01 ? {{16{rSigned & iwMemReadData[15]}}, iwMemReadData[15:0]} :
                        iwMemReadData;
    always_comb begin
        wNext = rState;
        case (rState)
            IDLE:      wNext = !wAccept ? IDLE : wBad ? ERROR : iwReqWrite ? WRITE : READ_WAIT;
            WRITE:     wNext = IDLE;
            READ_WAIT: wNext = wLoadDone ? IDLE : READ_WAIT;
            ERROR:     wNext = IDLE;
            default:   wNext = IDLE;
        endcase
    end
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) rState <= IDLE;
        else         rState <= wNext;
    end
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            orRespValid    <= 1'b0;
            orRespData     <= '0;
            orRespError    <= 1'b0;
            orMemReadAddr  <= '0;
            orMemWriteAddr <= '0;
            orMemWriteData <= '0;
            orMemWstrb     <= '0;
            rCnt           <= '0;
            rSize          <= '0;
            rSigned        <= 1'b0;
        end else begin
            orRespValid <= 1'b0;
            case (rState)
                IDLE: if (wAccept && !wBad) begin
                    if (iwReqWrite) begin
                        orMemWriteAddr <= iwReqAddr;
                        orMemWriteData <= iwReqWData;
                        orMemWstrb     <= iwReqSize == 2'b00 ? 4'b0001 : iwReqSize == 2'b01 ? 4'b0011 : 4'b1111;
                    end else begin
                        orMemReadAddr <= iwReqAddr;
                        rCnt          <= 4'(pReadWaitCycles);
                        rSize         <= iwReqSize;
                        rSigned       <= iwReqSigned;
                    end
                end
                WRITE: begin
                    orMemWstrb  <= 4'b0000;
                    orRespValid <= 1'b1;
                    orRespData  <= '0;
                    orRespError <= 1'b0;
                end
                READ_WAIT: begin
                    rCnt <= rCnt - 4'd1;
                    if (wLoadDone) begin
                        orRespValid <= 1'b1;
                        orRespData  <= wLoadData;
                        orRespError <= 1'b0;
                    end
                end
                ERROR: begin
                    orRespValid <= 1'b1;
                    orRespData  <= '0;
                    orRespError <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed checks plus multi-cycle sequences for the load/store unit.
module tb_load_store_unit;
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;
    logic clk, rst_n, valid, valid3, wr, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready1, resp_valid1, resp_err1;
    logic [31:0] resp_data1, raddr1, waddr1, wdata1, rdata1;
    logic [3:0]  wstrb1;
    logic        ready3, resp_valid3, resp_err3;
    logic [31:0] resp_data3, raddr3, waddr3, wdata3, rdata3;
    logic [3:0]  wstrb3;
    logic [7:0]  mem [0:255];
    logic [7:0]  ra1, ra3;
    int checks = 0;
    int errors = 0;
    vec_t vecs [22];

    load_store_unit #(.pReadWaitCycles(32'd1)) dut1 (
        .iwClk(clk), .iwnRst(rst_n), .iwReqValid(valid), .owReqReady(ready1),
        .iwReqWrite(wr), .iwReqSize(size), .iwReqSigned(sgn), .iwReqAddr(addr), .iwReqWData(wdata),
        .orRespValid(resp_valid1), .orRespData(resp_data1), .orRespError(resp_err1),
        .orMemReadAddr(raddr1), .orMemWriteAddr(waddr1), .orMemWriteData(wdata1),
        .orMemWstrb(wstrb1), .iwMemReadData(rdata1));

    load_store_unit #(.pReadWaitCycles(32'd3)) dut3 (
        .iwClk(clk), .iwnRst(rst_n), .iwReqValid(valid3), .owReqReady(ready3),
        .iwReqWrite(wr), .iwReqSize(size), .iwReqSigned(sgn), .iwReqAddr(addr), .iwReqWData(wdata),
        .orRespValid(resp_valid3), .orRespData(resp_data3), .orRespError(resp_err3),
        .orMemReadAddr(raddr3), .orMemWriteAddr(waddr3), .orMemWriteData(wdata3),
        .orMemWstrb(wstrb3), .iwMemReadData(rdata3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // byte-addressed memory: lane i of the read word is address+i
    assign ra1    = raddr1[7:0];
    assign ra3    = raddr3[7:0];
    assign rdata1 = {mem[ra1 + 8'd3], mem[ra1 + 8'd2], mem[ra1 + 8'd1], mem[ra1]};
    assign rdata3 = {mem[ra3 + 8'd3], mem[ra3 + 8'd2], mem[ra3 + 8'd1], mem[ra3]};
    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (wstrb1[i]) mem[waddr1[7:0] + 8'(i)] <= wdata1[8*i +: 8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        wr = v.wr; size = v.size; sgn = v.sgn; addr = v.addr; wdata = v.wdata; valid = 1'b1;
        chk($sformatf("v%0d_ready", idx), {31'b0, ready1}, 32'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        n = 0;
        while (!resp_valid1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("v%0d_latency", idx), n, 32'd1);
        chk($sformatf("v%0d_data", idx), resp_data1, v.exp_data);
        chk($sformatf("v%0d_error", idx), {31'b0, resp_err1}, {31'b0, v.exp_err});
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse_end", idx), {31'b0, resp_valid1}, 32'd0);
        chk($sformatf("v%0d_hold", idx), resp_data1, v.exp_data);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h000000DE, 1'b0};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h12345680, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'h00000080, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h21, 32'h00005555, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h22, 32'hAAAA7FFF, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        32'h00007FFF, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h7FFF0000, 1'b0};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1};
        vecs[16] = '{1'b1, 2'd2, 1'b0, 32'h31, 32'h99999999, 32'h0,        1'b1};
        vecs[17] = '{1'b1, 2'd0, 1'b0, 32'h31, 32'h000000FF, 32'h0,        1'b0};
        vecs[18] = '{1'b0, 2'd0, 1'b1, 32'h31, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[19] = '{1'b0, 2'd1, 1'b0, 32'h30, 32'h0,        32'h0000FF00, 1'b0};
        vecs[20] = '{1'b0, 2'd1, 1'b1, 32'h30, 32'h0,        32'hFFFFFF00, 1'b0};
        vecs[21] = '{1'b0, 2'd2, 1'b0, 32'h30, 32'h0,        32'h0000FF00, 1'b0};
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        rst_n = 1'b0; valid = 1'b0; valid3 = 1'b0; wr = 1'b0; size = 2'd0; sgn = 1'b0;
        addr = '0; wdata = '0;
        #12;
        chk("rst_ready", {31'b0, ready1}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid1}, 32'd0);
        chk("rst_wstrb", {28'b0, wstrb1}, 32'd0);
        chk("rst_addrs", raddr1 | waddr1 | wdata1 | resp_data1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // word store: strobe for exactly one cycle, then response
        @(negedge clk);
        wr = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'hDEADBEEF; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("st_wstrb_on", {28'b0, wstrb1}, 32'hF);
        chk("st_resp_early", {31'b0, resp_valid1}, 32'd0);
        @(posedge clk); #1;
        chk("st_wstrb_off", {28'b0, wstrb1}, 32'h0);
        chk("st_resp", {31'b0, resp_valid1}, 32'd1);
        chk("st_resp_err", {31'b0, resp_err1}, 32'd0);
        chk("st_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) run_vec(vecs[i], i);

        // long read latency: ready low 3 cycles, other requests ignored meanwhile
        @(negedge clk);
        wr = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h10; valid3 = 1'b1;
        @(posedge clk); #1;
        wr = 1'b1; addr = 32'h40; wdata = 32'h12345678;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("w3_ready_%0d", k), {31'b0, ready3}, 32'd0);
            chk($sformatf("w3_no_resp_%0d", k), {31'b0, resp_valid3}, 32'd0);
            @(posedge clk); #1;
        end
        chk("w3_ready_2", {31'b0, ready3}, 32'd0);
        chk("w3_wstrb", {28'b0, wstrb3}, 32'd0);
        @(posedge clk); #1;
        valid3 = 1'b0;
        chk("w3_resp", {31'b0, resp_valid3}, 32'd1);
        chk("w3_data", resp_data3, 32'hDEAD80EF);
        chk("w3_ready_back", {31'b0, ready3}, 32'd1);
        @(posedge clk); #1;
        chk("w3_pulse_end", {31'b0, resp_valid3}, 32'd0);
        chk("w3_ignored", raddr3, 32'h10);

        // reset mid-store: strobe drops immediately, no response follows
        @(negedge clk);
        wr = 1'b1; size = 2'd2; addr = 32'h50; wdata = 32'h11223344; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("rw_wstrb_on", {28'b0, wstrb1}, 32'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_wstrb_async", {28'b0, wstrb1}, 32'h0);
        chk("rw_waddr", waddr1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rw_no_resp_%0d", k), {31'b0, resp_valid1}, 32'd0);
        end
        chk("rw_ready", {31'b0, ready1}, 32'd1);
        chk("rw_mem", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'h0);

        // back-to-back stores with valid held: accept every second cycle
        @(negedge clk);
        wr = 1'b1; size = 2'd2; addr = 32'h60; wdata = 32'hCAFEF00D; valid = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                pulses += int'(resp_valid1);
                chk($sformatf("bb_resp_%0d", k), {31'b0, resp_valid1}, {31'b0, k % 2 == 0});
                chk($sformatf("bb_wstrb_%0d", k), {28'b0, wstrb1}, k % 2 == 1 ? 32'hF : 32'h0);
            end
            valid = 1'b0;
            chk("bb_pulses", pulses, 32'd4);
        end
        @(posedge clk); #1;
        chk("bb_idle", {31'b0, resp_valid1}, 32'd0);
        chk("bb_mem", {mem[8'h63], mem[8'h62], mem[8'h61], mem[8'h60]}, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: pReadWaitCycles, 32'd1, number of clock cycles from read-address issue to read-data capture (legal 1..15).
REQ-002 SHALL have port: iwClk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: iwnRst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: iwReqValid  in  1  CPU request valid.
REQ-005 SHALL have port: owReqReady  out  1  unit can accept a request this cycle.
REQ-006 SHALL have port: iwReqWrite  in  1  1 = store, 0 = load.
REQ-007 SHALL have port: iwReqSize  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port: iwReqSigned  in  1  load sign-extends when 1, zero-extends when 0.
REQ-009 SHALL have port: iwReqAddr  in  32  byte address.
REQ-010 SHALL have port: iwReqWData  in  32  store data, right-justified.
REQ-011 SHALL have port: orRespValid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: orRespData  out  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port: orRespError  out  1  valid with orRespValid; misaligned or reserved-size request.
REQ-014 SHALL have port: orMemReadAddr  out  32  byte read address to memory.
REQ-015 SHALL have port: orMemWriteAddr  out  32  byte write address to memory.
REQ-016 SHALL have port: orMemWriteData  out  32  write data; byte i on bits [8i+7:8i], written to address+i.
REQ-017 SHALL have port: orMemWstrb  out  4  byte write enables, lane i = address+i.
REQ-018 SHALL have port: iwMemReadData  in  32  memory read data; byte i from address+i.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, READ_WAIT, ERROR.
REQ-020 SHALL drive owReqReady = 1 only in IDLE; accept = iwReqValid & owReqReady at a rising edge.
REQ-021 SHALL flag an error on accept when size = 11, halfword with addr[0] = 1, or word with addr[1:0] != 00; an error request goes to ERROR and causes no memory write.
REQ-022 SHALL, on an accepted legal store, register orMemWriteAddr = iwReqAddr, orMemWriteData = iwReqWData, orMemWstrb = 0001/0011/1111 for byte/half/word, and go to WRITE.
REQ-023 SHALL, in WRITE, at the next edge, clear orMemWstrb to 0000, pulse orRespValid with orRespData = 0 and orRespError = 0, and return to IDLE (store latency 1 cycle).
REQ-024 SHALL hold orMemWstrb = 0000 in every state except WRITE.
REQ-025 SHALL, on an accepted legal load, register orMemReadAddr = iwReqAddr, load a wait counter with pReadWaitCycles, and go to READ_WAIT.
REQ-026 SHALL decrement the counter each cycle in READ_WAIT.
REQ-027 SHALL, at the edge where the counter reaches 1, sample iwMemReadData, pulse orRespValid with the extended data, and return to IDLE (load latency pReadWaitCycles cycles).
REQ-028 SHALL extend loads as follows: byte uses bits [7:0]; half uses bits [15:0]; the sign source is bit 7 or bit 15 when signed; the upper bits are zero when unsigned; a word passes through unchanged.
REQ-029 SHALL, in ERROR, at the next edge, pulse orRespValid with orRespError = 1 and orRespData = 0, and return to IDLE.
REQ-030 SHALL hold orRespValid high for exactly one cycle per accepted request and keep it low otherwise; orRespData and orRespError hold their last values when orRespValid = 0.
REQ-031 SHALL allow a new request to be accepted in the same cycle that orRespValid is high (IDLE), giving maximum throughput of one store per 2 cycles.
REQ-032 SHALL hold orMemReadAddr, orMemWriteAddr and orMemWriteData stable between accepts.
REQ-033 SHALL ignore iwReqValid and all request inputs outside IDLE.

Reset
REQ-034 SHALL, on iwnRst low at any time including mid-operation, immediately force state IDLE, orMemWstrb = 0000, orRespValid = 0, orRespError = 0, orRespData = 0, orMemReadAddr = orMemWriteAddr = orMemWriteData = 0, and the wait counter to 0; owReqReady SHALL be 1 after release.
REQ-035 SHALL NOT produce a response for a request interrupted by reset.

Verification
REQ-036 SHALL cover: word store, addr 0x10, data 0xDEADBEEF -> wstrb 1111 for one cycle, memory bytes 0x10..0x13 = EF BE AD DE, orRespValid one cycle later with error 0.
REQ-037 SHALL cover: signed byte load, addr 0x11, memory byte 0x80 -> orRespData 0xFFFFFF80; the same load unsigned -> 0x00000080; both with pReadWaitCycles = 1, response 1 cycle after accept.
REQ-038 SHALL cover: halfword store, addr 0x21 -> no wstrb activity, orRespValid with orRespError = 1 and orRespData = 0 one cycle after accept.
REQ-039 SHALL cover: pReadWaitCycles = 3, word load -> owReqReady low for 3 cycles, orRespValid on the third edge after accept, and iwReqValid during the wait is ignored.
REQ-040 SHALL cover: iwnRst asserted while in WRITE with wstrb 1111 -> wstrb 0000 asynchronously and no orRespValid follows.
REQ-041 SHALL cover: back-to-back stores with iwReqValid held high -> accepts every second cycle, and each store produces exactly one response pulse.
